// File: rtl/cal_pkg.sv
// Shared constants and types for the calculator command parser: ASCII codes,
// opcode and error encodings, and the parser state type.
package cal_pkg;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;
    localparam logic [7:0] ASCII_SLASH = 8'h2F;
    localparam logic [7:0] ASCII_EQ    = 8'h3D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_SYNTAX   = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;
    localparam logic [1:0] ERR_OVERRUN  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPA,
        ST_OPB,
        ST_HOLD,
        ST_ERR
    } parser_state_t;

endpackage

// File: rtl/cal_cmd_parser_if.sv
// Byte-in / command-out bundle of the parser. Echo signals exist only when
// CAL_PARSER_ECHO_EN is defined.
interface cal_cmd_parser_if #(
    parameter int DATA_W = 16
);
    // Command handshake: the parser raises cmd_valid and holds op_a/op_b/opcode
    // stable until a cycle with cmd_valid && cmd_ready; the command transfers there.
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [1:0]        opcode;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              err;
    logic [1:0]        err_code;
`ifdef CAL_PARSER_ECHO_EN
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;
`endif

    modport master (
        input  rx_data, rx_valid, cmd_ready,
`ifdef CAL_PARSER_ECHO_EN
        input  tx_busy,
        output tx_data, tx_start,
`endif
        output op_a, op_b, opcode, cmd_valid, err, err_code
    );

    modport slave (
        output rx_data, rx_valid, cmd_ready,
`ifdef CAL_PARSER_ECHO_EN
        output tx_busy,
        input  tx_data, tx_start,
`endif
        input  op_a, op_b, opcode, cmd_valid, err, err_code
    );

endinterface

// File: rtl/cal_ascii_class.sv
// Combinational byte classifier: digit/op/term/space flags, digit value and opcode.
module cal_ascii_class
    import cal_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic       is_digit_o,
    output logic       is_op_o,
    output logic       is_term_o,
    output logic       is_space_o,
    output logic [3:0] digit_o,
    output logic [1:0] op_o
);

    assign is_digit_o = (byte_i >= ASCII_0) && (byte_i <= ASCII_9);
    assign is_term_o  = (byte_i == ASCII_EQ) || (byte_i == ASCII_CR);
    assign is_space_o = (byte_i == ASCII_SPACE) || (byte_i == ASCII_LF);
    // ASCII digits sit at 0x30..0x39, so the low nibble is the value.
    assign digit_o    = byte_i[3:0];

    always_comb begin
        is_op_o = 1'b0;
        op_o    = OP_ADD;
        case (byte_i)
            ASCII_PLUS:  begin is_op_o = 1'b1; op_o = OP_ADD; end
            ASCII_MINUS: begin is_op_o = 1'b1; op_o = OP_SUB; end
            ASCII_STAR:  begin is_op_o = 1'b1; op_o = OP_MUL; end
            ASCII_SLASH: begin is_op_o = 1'b1; op_o = OP_DIV; end
            default:     ;
        endcase
    end

endmodule

// File: rtl/cal_cmd_parser.sv
// Parses "<A><op><B><term>" ASCII lines into a binary command with error flags.
// Optional byte echo to a UART transmitter is built when CAL_PARSER_ECHO_EN is defined.
module cal_cmd_parser
    import cal_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int MAX_DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    cal_cmd_parser_if.master    cmd_if,
    output parser_state_t       state_o
);

    localparam int               CNT_W    = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_DIGITS);

    parser_state_t     state_q, state_d;
    logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [1:0]        opcode_q, opcode_d, err_code_q, err_code_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cmd_valid_q, cmd_valid_d, err_q, err_d;

    logic              is_digit, is_op, is_term, is_space;
    logic [3:0]        digit;
    logic [1:0]        op;
    logic              rx_valid;
    logic [DATA_W-1:0] digit_ext;

    assign rx_valid  = cmd_if.rx_valid;
    assign digit_ext = {{(DATA_W-4){1'b0}}, digit};

    cal_ascii_class u_class (
        .byte_i     (cmd_if.rx_data),
        .is_digit_o (is_digit),
        .is_op_o    (is_op),
        .is_term_o  (is_term),
        .is_space_o (is_space),
        .digit_o    (digit),
        .op_o       (op)
    );

    // acc*10 + d without a multiplier; the digit limit keeps it from wrapping.
    function automatic logic [DATA_W-1:0] acc10(input logic [DATA_W-1:0] acc,
                                                input logic [DATA_W-1:0] d);
        return (acc << 3) + (acc << 1) + d;
    endfunction

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        opcode_d    = opcode_q;
        cnt_d       = cnt_q;
        cmd_valid_d = cmd_valid_q;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        case (state_q)
            ST_IDLE: if (rx_valid) begin
                if (is_digit) begin
                    op_a_d  = digit_ext;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_OPA;
                end else if (!(is_term || is_space)) begin
                    err_d = 1'b1; err_code_d = ERR_SYNTAX; state_d = ST_ERR;
                end
            end
            ST_OPA: if (rx_valid) begin
                if (is_digit && cnt_q == CNT_FULL) begin
                    err_d = 1'b1; err_code_d = ERR_OVERFLOW; state_d = ST_ERR;
                end else if (is_digit) begin
                    op_a_d = acc10(op_a_q, digit_ext);
                    cnt_d  = cnt_q + CNT_W'(1);
                end else if (is_op) begin
                    opcode_d = op;
                    op_b_d   = '0;
                    cnt_d    = '0;
                    state_d  = ST_OPB;
                end else if (!is_space) begin
                    err_d = 1'b1; err_code_d = ERR_SYNTAX; state_d = ST_ERR;
                end
            end
            ST_OPB: if (rx_valid) begin
                if (is_digit && cnt_q == CNT_FULL) begin
                    err_d = 1'b1; err_code_d = ERR_OVERFLOW; state_d = ST_ERR;
                end else if (is_digit) begin
                    op_b_d = acc10(op_b_q, digit_ext);
                    cnt_d  = cnt_q + CNT_W'(1);
                end else if (is_term && cnt_q != '0) begin
                    cmd_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else if (is_term) begin
                    // The line already ended, so there is nothing left to discard.
                    err_d = 1'b1; err_code_d = ERR_SYNTAX; state_d = ST_IDLE;
                end else if (!is_space) begin
                    err_d = 1'b1; err_code_d = ERR_SYNTAX; state_d = ST_ERR;
                end
            end
            ST_HOLD: begin
                if (rx_valid) begin
                    err_d = 1'b1; err_code_d = ERR_OVERRUN;
                end
                if (cmd_valid_q && cmd_if.cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_ERR: if (rx_valid && is_term) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            opcode_q    <= OP_ADD;
            cnt_q       <= '0;
            cmd_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            opcode_q    <= opcode_d;
            cnt_q       <= cnt_d;
            cmd_valid_q <= cmd_valid_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign cmd_if.op_a      = op_a_q;
    assign cmd_if.op_b      = op_b_q;
    assign cmd_if.opcode    = opcode_q;
    assign cmd_if.cmd_valid = cmd_valid_q;
    assign cmd_if.err       = err_q;
    assign cmd_if.err_code  = err_code_q;
    assign state_o          = state_q;

`ifdef CAL_PARSER_ECHO_EN
    // Bytes dropped as overrun are not echoed; a busy transmitter loses the echo.
    logic [7:0] tx_data_q;
    logic       tx_start_q;
    logic       echo_d;

    assign echo_d = rx_valid && (state_q != ST_HOLD) && !cmd_if.tx_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            tx_start_q <= echo_d;
            if (echo_d) tx_data_q <= cmd_if.rx_data;
        end
    end

    assign cmd_if.tx_data  = tx_data_q;
    assign cmd_if.tx_start = tx_start_q;
`endif

endmodule

// File: tb/tb_cal_cmd_parser.sv
// Directed bench for cal_cmd_parser: table of ASCII lines plus hand sequences
// for backpressure, reset mid-parse and (with CAL_PARSER_ECHO_EN) echo.
module tb_cal_cmd_parser;
    import cal_pkg::*;

    typedef struct {
        logic [95:0] text;
        int          len;
        int          gap;
        logic        exp_cmd;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        int          term_idx;
        logic        exp_err;
        logic [1:0]  code;
        int          err_idx;
    } vec_t;

    localparam int NVEC = 13;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    parser_state_t state;
    int            cyc = 0;
    int            tests = 0;
    int            fails = 0;
    logic [33:0]   exp_q[$];
    int            strobe_q[$];
    logic [1:0]    last_code;
    vec_t          vec[NVEC];

    // Monitor-owned observations
    int            cmd_seen = 0, hi_cycles = 0, rise_cyc = 0;
    int            err_seen = 0, err_cyc = 0;
    logic [1:0]    err_code_seen = 2'd0;
    logic [33:0]   got_payload = '0;
    logic          cv_prev = 1'b0;

    cal_cmd_parser_if #(.DATA_W(16)) bus ();

    cal_cmd_parser #(.DATA_W(16), .MAX_DIGITS(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd_if  (bus),
        .state_o (state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            cv_prev <= 1'b0;
        end else begin
            if (bus.cmd_valid) hi_cycles <= hi_cycles + 1;
            if (bus.cmd_valid && !cv_prev) begin
                cmd_seen    <= cmd_seen + 1;
                rise_cyc    <= cyc;
                got_payload <= {bus.op_a, bus.op_b, bus.opcode};
            end
            cv_prev <= bus.cmd_valid;
            if (bus.err) begin
                err_seen      <= err_seen + 1;
                err_code_seen <= bus.err_code;
                err_cyc       <= cyc;
            end
        end
    end

`ifdef CAL_PARSER_ECHO_EN
    logic [7:0] tx_log[16];
    int         tx_seen = 0;
    always @(negedge clk) begin
        if (!rst && bus.tx_start) begin
            tx_log[tx_seen % 16] <= bus.tx_data;
            tx_seen              <= tx_seen + 1;
        end
    end
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered and left #1 after a rising edge; gap=0 gives back-to-back strobes.
    task automatic send_line(input logic [95:0] text, input int len, input int gap);
        strobe_q.delete();
        for (int i = 0; i < len; i++) begin
            bus.rx_data  = text[8*(len-1-i) +: 8];
            bus.rx_valid = 1'b1;
            strobe_q.push_back(cyc);
            @(posedge clk); #1;
            bus.rx_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic settle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   cmd_base, hi_base, err_base;
        v        = vec[idx];
        cmd_base = cmd_seen;
        hi_base  = hi_cycles;
        err_base = err_seen;
        if (v.exp_cmd) exp_q.push_back({v.a, v.b, v.op});
        send_line(v.text, v.len, v.gap);
        settle(6);
        check($sformatf("v%0d_cmd_count", idx), cmd_seen - cmd_base, v.exp_cmd);
        if (v.exp_cmd && exp_q.size() > 0) begin
            check($sformatf("v%0d_cmd_payload", idx), got_payload, exp_q.pop_front());
            check($sformatf("v%0d_cmd_latency", idx), rise_cyc, strobe_q[v.term_idx] + 1);
            check($sformatf("v%0d_cmd_valid_cycles", idx), hi_cycles - hi_base, 1);
        end
        check($sformatf("v%0d_err_count", idx), err_seen - err_base, v.exp_err);
        if (v.exp_err) begin
            last_code = v.code;
            check($sformatf("v%0d_err_code", idx), err_code_seen, v.code);
            check($sformatf("v%0d_err_latency", idx), err_cyc, strobe_q[v.err_idx] + 1);
        end
        check($sformatf("v%0d_err_code_hold", idx), bus.err_code, last_code);
        check($sformatf("v%0d_state_idle", idx), state, ST_IDLE);
    endtask

    initial begin
        int base;

        vec[0]  = '{"12+34\015",       6, 9, 1'b1, 16'd12,   16'd34,   2'd0, 5, 1'b0, 2'd0, 0};
        vec[1]  = '{"9999*9999=",     10, 0, 1'b1, 16'd9999, 16'd9999, 2'd2, 9, 1'b0, 2'd0, 0};
        vec[2]  = '{"12345+1=",        8, 0, 1'b0, 16'd0,    16'd0,    2'd0, 0, 1'b1, 2'd2, 4};
        vec[3]  = '{"7/2=",            4, 0, 1'b1, 16'd7,    16'd2,    2'd3, 3, 1'b0, 2'd0, 0};
        vec[4]  = '{"+5=",             3, 0, 1'b0, 16'd0,    16'd0,    2'd0, 0, 1'b1, 2'd1, 0};
        vec[5]  = '{"5+=",             3, 0, 1'b0, 16'd0,    16'd0,    2'd0, 0, 1'b1, 2'd1, 2};
        vec[6]  = '{" 4 / 2 \015\012", 9, 0, 1'b1, 16'd4,    16'd2,    2'd3, 7, 1'b1, 2'd3, 8};
        vec[7]  = '{"=\015",           2, 0, 1'b0, 16'd0,    16'd0,    2'd0, 0, 1'b0, 2'd0, 0};
        vec[8]  = '{"1 2+3=",          6, 0, 1'b1, 16'd12,   16'd3,    2'd0, 5, 1'b0, 2'd0, 0};
        vec[9]  = '{"5==",             3, 0, 1'b0, 16'd0,    16'd0,    2'd0, 0, 1'b1, 2'd1, 1};
        vec[10] = '{"12+34x=",         7, 0, 1'b0, 16'd0,    16'd0,    2'd0, 0, 1'b1, 2'd1, 5};
        vec[11] = '{"12+12345=",       9, 0, 1'b0, 16'd0,    16'd0,    2'd0, 0, 1'b1, 2'd2, 7};
        vec[12] = '{"0-0=",            4, 3, 1'b1, 16'd0,    16'd0,    2'd1, 3, 1'b0, 2'd0, 0};

        bus.rx_data   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.cmd_ready = 1'b1;
`ifdef CAL_PARSER_ECHO_EN
        bus.tx_busy   = 1'b0;
`endif
        last_code     = ERR_NONE;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_state", state, ST_IDLE);
        check("reset_cmd_valid", bus.cmd_valid, 1'b0);
        check("reset_err_code", bus.err_code, ERR_NONE);

        for (int i = 0; i < NVEC; i++) run_vec(i);

        // Backpressure: command held, later byte dropped as overrun
        bus.cmd_ready = 1'b0;
        base = err_seen;
        send_line("5-3=", 4, 0);
        settle(3);
        check("bp_cmd_valid", bus.cmd_valid, 1'b1);
        check("bp_payload", {bus.op_a, bus.op_b, bus.opcode}, {16'd5, 16'd3, 2'd1});
        check("bp_state_hold", state, ST_HOLD);
        send_line("1", 1, 0);
        check("bp_overrun_err", bus.err, 1'b1);
        settle(2);
        check("bp_overrun_count", err_seen - base, 1);
        check("bp_overrun_code", err_code_seen, ERR_OVERRUN);
        check("bp_overrun_latency", err_cyc, strobe_q[0] + 1);
        check("bp_frozen", {bus.cmd_valid, bus.op_a, bus.op_b, bus.opcode}, {1'b1, 16'd5, 16'd3, 2'd1});
        // Handshake and a stray byte on the same cycle
        base = err_seen;
        bus.cmd_ready = 1'b1;
        send_line("9", 1, 0);
        check("bp_release_cmd_valid", bus.cmd_valid, 1'b0);
        check("bp_release_state", state, ST_IDLE);
        settle(2);
        check("bp_release_overrun", err_seen - base, 1);
        check("bp_release_code", bus.err_code, ERR_OVERRUN);

        // Reset mid-parse
        send_line("12+3", 4, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_outputs", {bus.op_a, bus.op_b, bus.opcode, bus.cmd_valid, bus.err, bus.err_code},
              35'd0);
        check("rst_state", state, ST_IDLE);
        base = cmd_seen;
        send_line("6+1=", 4, 0);
        settle(4);
        check("rst_after_count", cmd_seen - base, 1);
        check("rst_after_payload", got_payload, {16'd6, 16'd1, 2'd0});

`ifdef CAL_PARSER_ECHO_EN
        base = tx_seen;
        send_line("8*2=", 4, 2);
        settle(4);
        check("echo_count", tx_seen - base, 4);
        check("echo_bytes", {tx_log[base % 16], tx_log[(base+1) % 16], tx_log[(base+2) % 16],
              tx_log[(base+3) % 16]}, 32'h382A323D);
        base = tx_seen;
        send_line("8", 1, 2);
        bus.tx_busy = 1'b1;
        send_line("*", 1, 0);
        settle(1);
        bus.tx_busy = 1'b0;
        send_line("2=", 2, 2);
        settle(4);
        check("echo_busy_count", tx_seen - base, 3);
        check("echo_busy_bytes", {tx_log[base % 16], tx_log[(base+1) % 16], tx_log[(base+2) % 16]},
              24'h38323D);
        check("echo_busy_cmd", got_payload, {16'd8, 16'd2, 2'd2});
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cal_cmd_parser.md
Name: cal_cmd_parser

Overview:
- Sits directly downstream of the UART receiver in the calculator datapath.
- Consumes received ASCII bytes (8-bit data plus a one-cycle valid pulse) and parses lines of the form `<A><op><B><term>`.
- Presents binary operands and an opcode to the calculator core over a valid/ready handshake.
- Flags malformed input, digit overflow, and bytes lost while a command is pending.

Parameters:
- DATA_W, 16, operand width in bits.
- MAX_DIGITS, 4, maximum decimal digits per operand. 10^MAX_DIGITS-1 must fit in DATA_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- rx_data  in  8  received byte; sampled only when rx_valid=1.
- rx_valid  in  1  one-cycle byte strobe; may repeat on back-to-back cycles.
- op_a  out  DATA_W  operand A.
- op_b  out  DATA_W  operand B.
- opcode  out  2  operator: 0 '+', 1 '-', 2 '*', 3 '/'.
- cmd_valid  out  1  command available.
- cmd_ready  in  1  calculator accepts command.
- err  out  1  one-cycle error pulse.
- err_code  out  2  error cause: 1 syntax, 2 digit overflow, 3 overrun. Holds its last value between pulses.
- Interface rule (already decided): one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst=1 at a clk edge) sets op_a=0, op_b=0, opcode=0, cmd_valid=0, err=0, err_code=0, digit count=0, state=IDLE. Reset mid-parse discards the partial line.
- Byte classes:
  - digit: 0x30-0x39.
  - op: 0x2B, 0x2D, 0x2A, 0x2F.
  - term: '=' (0x3D) or CR (0x0D).
  - space: 0x20 or LF (0x0A). Spaces are ignored in IDLE, OPA and OPB.
  - other: any remaining value.
- Accumulate rule: acc <= acc*10 + (byte-0x30), computed as (acc<<3)+(acc<<1)+d, truncated to DATA_W. The digit counter prevents truncation from ever occurring.
- IDLE:
  - digit: op_a=d, cnt=1, go to OPA.
  - term: ignored (empty line).
  - op or other: syntax error, go to ERR.
- OPA:
  - digit with cnt<MAX_DIGITS: accumulate into op_a, cnt+1.
  - digit with cnt==MAX_DIGITS: overflow error, go to ERR.
  - op: latch opcode, clear op_b and cnt, go to OPB.
  - term or other: syntax error, go to ERR.
- OPB:
  - digit: same accumulate and overflow rules as OPA, into op_b.
  - term with cnt>=1: cmd_valid=1, go to HOLD.
  - term with cnt=0, op, or other: syntax error. A term-caused error returns directly to IDLE; otherwise go to ERR.
- HOLD:
  - op_a, op_b, opcode stay frozen while cmd_valid=1.
  - cmd_valid&&cmd_ready: cmd_valid=0 on the next edge, go to IDLE.
  - Any rx_valid while in HOLD, including the handshake cycle, drops the byte and raises an overrun error. State is unchanged.
- ERR: discard bytes until a term arrives, then go to IDLE. No further err pulse is raised.
- Error timing: err is high exactly on the cycle after the offending rx_valid, with err_code valid on the same cycle.
- Latency: cmd_valid rises one cycle after the terminating rx_valid.

Optional Feature:
- Macro: CAL_PARSER_ECHO_EN.
- When defined, three extra ports are added:
  - tx_data  out  8  echoed byte.
  - tx_start  out  1  one-cycle echo strobe.
  - tx_busy  in  1  transmitter busy.
- Echo behaviour when defined:
  - Every byte not dropped for overrun is echoed: tx_data gets the byte and tx_start pulses one cycle after rx_valid.
  - If tx_busy=1 on that cycle, the echo is skipped. There is no buffering.
  - Reset values: tx_data=0, tx_start=0.
- When undefined: the ports and logic are absent, and parser behaviour is identical.

Decomposition:
- Shared package cal_pkg holds:
  - ASCII constants.
  - Opcode encodings.
  - Parser state typedef (IDLE, OPA, OPB, HOLD, ERR).
  - Error-code constants.
- One combinational sub-module, cal_ascii_class, decodes a byte into is_digit, is_op, is_term, is_space, digit value and opcode.
- The FSM, accumulators and handshake live in cal_cmd_parser.

Test Plan:
- Normal command: "12+34\r" sent one byte per 10 cycles, cmd_ready=1 -> a single cmd_valid cycle with op_a=12, op_b=34, opcode=0. cmd_valid rises one cycle after the CR strobe.
- Overflow, then recovery:
  - "9999*9999=" -> op_a=9999, op_b=9999, opcode=2.
  - "12345+1=" -> err=1 with err_code=2 one cycle after the '5'; no cmd_valid.
  - A following "7/2=" -> op_a=7, op_b=2, opcode=3.
- Backpressure: cmd_ready=0 and "5-3=" sent, then "1" sent -> cmd_valid stays 1 with 5/3/1 frozen, and err_code=3 pulses. Raising cmd_ready drops cmd_valid on the next cycle.
- Syntax and whitespace:
  - "+5=" -> err_code=1.
  - "5+=" -> err_code=1, then IDLE.
  - " 4 / 2 \r\n" -> op_a=4, op_b=2, opcode=3.
  - All bytes sent on back-to-back cycles.
- Reset mid-parse: "12+3" then rst high for 1 cycle -> all outputs 0. A following "6+1=" -> op_a=6, op_b=1, opcode=0.
- Echo (CAL_PARSER_ECHO_EN defined): "8*2=" with tx_busy=0 -> four tx_start pulses carrying 0x38, 0x2A, 0x32, 0x3D. With tx_busy=1 during '*', that byte is not echoed.
